// File: rtl/serial_bus_arbiter.sv
// serial_bus_arbiter: central arbiter for the serial bus.
// Grants one master at a time, pulses split_en when a slave splits the
// current transfer, parks the split master until its slave is ready, then
// gives that master first claim on the bus.
// Optional build macro SERIAL_ARB_ROUND_ROBIN_EN: round-robin selection among
// non-split candidates (default build: fixed priority, lowest index wins).
//
// Handshake: a master holds bus_req high (level) until it is done. The
// arbiter answers with a one-hot bus_grant. The granted master raises
// bus_util within GRANT_TIMEOUT cycles to claim the bus, or the grant is
// revoked. Dropping bus_util (or dropping bus_req before using the bus)
// releases ownership. Every owner change passes through one IDLE cycle.
module serial_bus_arbiter #(
   parameter int MASTER_NO     = 2,
   parameter int SLAVE_NO      = 5,
   parameter int MID_W         = 1,
   parameter int GRANT_TIMEOUT = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [MASTER_NO-1:0] bus_req,
   input  logic [MASTER_NO-1:0] bus_util,
   output logic [MASTER_NO-1:0] bus_grant,
   output logic [MASTER_NO-1:0] split_en,
   input  logic [SLAVE_NO-1:0]  s_split_req,
   input  logic [SLAVE_NO-1:0]  s_split_ready,
   output logic [MID_W-1:0]     owner_id,
   output logic                 bus_busy,
   output logic                 split_pending,
   output logic [1:0]           state_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      BUSY  = 2'd2,
      SPLIT = 2'd3
   } state_t;

   localparam int SS_W = (SLAVE_NO > 1) ? $clog2(SLAVE_NO) : 1;
   localparam int TM_W = $clog2(GRANT_TIMEOUT + 1);
   localparam logic [TM_W-1:0] TM_LAST = TM_W'(GRANT_TIMEOUT - 1);

   state_t                 state_q, state_d;
   logic [MASTER_NO-1:0]   grant_q, grant_d;
   logic [MASTER_NO-1:0]   split_en_q, split_en_d;
   logic [MID_W-1:0]       owner_q, owner_d;
   logic [MID_W-1:0]       split_master_q, split_master_d;
   logic [SS_W-1:0]        split_slave_q, split_slave_d;
   logic                   busy_q, busy_d;
   logic                   pending_q, pending_d;
   logic [TM_W-1:0]        timer_q, timer_d;

   logic [MASTER_NO-1:0]   eligible;
   logic                   resume;
   logic                   pick_vld;
   logic [MID_W-1:0]       pick_idx;
   logic [MID_W-1:0]       gnt_idx;
   logic [SS_W-1:0]        split_lsb;

`ifdef SERIAL_ARB_ROUND_ROBIN_EN
   logic [MID_W-1:0]       last_owner_q, last_owner_d;
   int                     rr_idx;
`endif

   // Candidate masters: the parked split master is hidden until its slave is ready.
   always_comb begin
      eligible = bus_req;
      if (pending_q && !s_split_ready[split_slave_q]) begin
         eligible[split_master_q] = 1'b0;
      end
   end

   assign resume  = pending_q && s_split_ready[split_slave_q] && bus_req[split_master_q];
   assign gnt_idx = resume ? split_master_q : pick_idx;

`ifdef SERIAL_ARB_ROUND_ROBIN_EN
   // Round-robin pick: search starts one past the last owner and wraps.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      rr_idx   = 0;
      for (int i = MASTER_NO - 1; i >= 0; i--) begin
         rr_idx = (int'(last_owner_q) + 1 + i) % MASTER_NO;
         if (eligible[MID_W'(rr_idx)]) begin
            pick_vld = 1'b1;
            pick_idx = MID_W'(rr_idx);
         end
      end
   end
`else
   // Fixed-priority pick: lowest index wins.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int i = MASTER_NO - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            pick_vld = 1'b1;
            pick_idx = MID_W'(i);
         end
      end
   end
`endif

   // Lowest-index slave asking for a split is the one recorded.
   always_comb begin
      split_lsb = '0;
      for (int i = SLAVE_NO - 1; i >= 0; i--) begin
         if (s_split_req[i]) split_lsb = SS_W'(i);
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d        = state_q;
      grant_d        = grant_q;
      split_en_d     = '0;
      owner_d        = owner_q;
      busy_d         = busy_q;
      pending_d      = pending_q;
      timer_d        = timer_q;
      split_master_d = split_master_q;
      split_slave_d  = split_slave_q;
`ifdef SERIAL_ARB_ROUND_ROBIN_EN
      last_owner_d   = last_owner_q;
`endif
      case (state_q)
         IDLE: begin
            grant_d = '0;
            busy_d  = 1'b0;
            if (resume || pick_vld) begin
               for (int i = 0; i < MASTER_NO; i++) begin
                  grant_d[i] = (MID_W'(i) == gnt_idx);
               end
               owner_d = gnt_idx;
               busy_d  = 1'b1;
               timer_d = '0;
               state_d = GRANT;
               if (resume) pending_d = 1'b0;
`ifdef SERIAL_ARB_ROUND_ROBIN_EN
               last_owner_d = gnt_idx;
`endif
            end
         end
         GRANT: begin
            if (bus_util[owner_q]) begin
               state_d = BUSY;
            end else if (!bus_req[owner_q] || (timer_q == TM_LAST)) begin
               grant_d = '0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               timer_d = timer_q + TM_W'(1);
            end
         end
         BUSY: begin
            // Release has priority over a split request in the same cycle.
            if (!bus_util[owner_q]) begin
               grant_d = '0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else if ((|s_split_req) && !pending_q) begin
               split_master_d      = owner_q;
               split_slave_d       = split_lsb;
               split_en_d[owner_q] = 1'b1;
               grant_d             = '0;
               busy_d              = 1'b0;
               state_d             = SPLIT;
            end
         end
         SPLIT: begin
            pending_d = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            grant_d = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset clears grants and any pending split.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         grant_q        <= '0;
         split_en_q     <= '0;
         owner_q        <= '0;
         busy_q         <= 1'b0;
         pending_q      <= 1'b0;
         timer_q        <= '0;
         split_master_q <= '0;
         split_slave_q  <= '0;
`ifdef SERIAL_ARB_ROUND_ROBIN_EN
         last_owner_q   <= '0;
`endif
      end else begin
         state_q        <= state_d;
         grant_q        <= grant_d;
         split_en_q     <= split_en_d;
         owner_q        <= owner_d;
         busy_q         <= busy_d;
         pending_q      <= pending_d;
         timer_q        <= timer_d;
         split_master_q <= split_master_d;
         split_slave_q  <= split_slave_d;
`ifdef SERIAL_ARB_ROUND_ROBIN_EN
         last_owner_q   <= last_owner_d;
`endif
      end
   end

   assign bus_grant     = grant_q;
   assign split_en      = split_en_q;
   assign owner_id      = owner_q;
   assign bus_busy      = busy_q;
   assign split_pending = pending_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// tb_serial_bus_arbiter: directed table-driven bench for serial_bus_arbiter
// with hand-written sequences for grant timeout and mid-transfer reset.
`timescale 1ns/1ps
module tb_serial_bus_arbiter;

   localparam int MASTER_NO     = 2;
   localparam int SLAVE_NO      = 5;
   localparam int MID_W         = 1;
   localparam int GRANT_TIMEOUT = 8;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_BUSY  = 2'd2;
   localparam logic [1:0] S_SPLIT = 2'd3;

   // clock / reset
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [MASTER_NO-1:0] bus_req, bus_util, bus_grant, split_en;
   logic [SLAVE_NO-1:0]  s_split_req, s_split_ready;
   logic [MID_W-1:0]     owner_id;
   logic                 bus_busy, split_pending;
   logic [1:0]           state_o;

   serial_bus_arbiter #(
      .MASTER_NO(MASTER_NO), .SLAVE_NO(SLAVE_NO),
      .MID_W(MID_W), .GRANT_TIMEOUT(GRANT_TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .bus_req(bus_req), .bus_util(bus_util),
      .bus_grant(bus_grant), .split_en(split_en),
      .s_split_req(s_split_req), .s_split_ready(s_split_ready),
      .owner_id(owner_id), .bus_busy(bus_busy),
      .split_pending(split_pending), .state_o(state_o)
   );

   typedef struct {
      logic [1:0] req;
      logic [1:0] util;
      logic [4:0] sreq;
      logic [4:0] srdy;
      logic [1:0] e_grant;
      logic [1:0] e_sen;
      logic       e_owner;
      logic       e_busy;
      logic       e_pend;
      logic [1:0] e_state;
   } vec_t;

   vec_t vecs[$];
   int   total = 0;
   int   bad   = 0;
   int   part_a_end;

   task automatic add_vec(input logic [1:0] req, input logic [1:0] util,
                          input logic [4:0] sreq, input logic [4:0] srdy,
                          input logic [1:0] g, input logic [1:0] s,
                          input logic o, input logic b, input logic p,
                          input logic [1:0] st);
      vec_t v;
      v.req = req; v.util = util; v.sreq = sreq; v.srdy = srdy;
      v.e_grant = g; v.e_sen = s; v.e_owner = o; v.e_busy = b;
      v.e_pend = p; v.e_state = st;
      vecs.push_back(v);
   endtask

   // driver tasks
   task automatic drive(input logic [1:0] req, input logic [1:0] util,
                        input logic [4:0] sreq, input logic [4:0] srdy);
      bus_req       = req;
      bus_util      = util;
      s_split_req   = sreq;
      s_split_ready = srdy;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // scoreboard: owner_id is only meaningful while busy is expected
   task automatic check(input string name, input logic [1:0] g, input logic [1:0] s,
                        input logic o, input logic b, input logic p, input logic [1:0] st);
      logic [8:0] act_v, exp_v;
      act_v = {state_o, bus_grant, split_en, (b ? owner_id : 1'b0), bus_busy, split_pending};
      exp_v = {st, g, s, (b ? o : 1'b0), b, p};
      total++;
      if (act_v !== exp_v) begin
         bad++;
         $display("FAIL %s: got state=%0d grant=%b split_en=%b owner=%0d busy=%b pend=%b, want state=%0d grant=%b split_en=%b owner=%0d busy=%b pend=%b",
                  name, state_o, bus_grant, split_en, owner_id, bus_busy, split_pending,
                  st, g, s, o, b, p);
      end
   endtask

   task automatic check_reset(input string name);
      logic [8:0] act_v;
      act_v = {state_o, bus_grant, split_en, owner_id, bus_busy, split_pending};
      total++;
      if (act_v !== 9'd0) begin
         bad++;
         $display("FAIL %s: got state=%0d grant=%b split_en=%b owner=%0d busy=%b pend=%b, want all zero",
                  name, state_o, bus_grant, split_en, owner_id, bus_busy, split_pending);
      end
   endtask

   task automatic apply_vec(input int i);
      drive(vecs[i].req, vecs[i].util, vecs[i].sreq, vecs[i].srdy);
      step();
      check($sformatf("vec%0d", i), vecs[i].e_grant, vecs[i].e_sen, vecs[i].e_owner,
            vecs[i].e_busy, vecs[i].e_pend, vecs[i].e_state);
   endtask

   initial begin
      //           req    util   sreq      srdy      grant  sen    own  busy pend state
      // master0 request, use for 5 cycles, release
      add_vec(2'b01, 2'b00, 5'b00000, 5'b00000, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, S_GRANT);
      add_vec(2'b01, 2'b00, 5'b00000, 5'b00000, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, S_GRANT);
      for (int k = 0; k < 5; k++)
         add_vec(2'b01, 2'b01, 5'b00000, 5'b00000, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, S_BUSY);
      add_vec(2'b00, 2'b00, 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, S_IDLE);
      add_vec(2'b00, 2'b00, 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, S_IDLE);
      // simultaneous requests, then re-arbitration
      add_vec(2'b11, 2'b00, 5'b00000, 5'b00000, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, S_GRANT);
      add_vec(2'b11, 2'b01, 5'b00000, 5'b00000, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, S_BUSY);
      add_vec(2'b11, 2'b00, 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, S_IDLE);
`ifdef SERIAL_ARB_ROUND_ROBIN_EN
      add_vec(2'b11, 2'b00, 5'b00000, 5'b00000, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, S_GRANT);
`else
      add_vec(2'b11, 2'b00, 5'b00000, 5'b00000, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, S_GRANT);
`endif
      add_vec(2'b00, 2'b00, 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, S_IDLE);
      add_vec(2'b00, 2'b00, 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, S_IDLE);
      part_a_end = vecs.size();
      // master0 split by slave 2, parked until slave 2 ready
      add_vec(2'b01, 2'b00, 5'b00000, 5'b00000, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, S_GRANT);
      add_vec(2'b01, 2'b01, 5'b00000, 5'b00000, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, S_BUSY);
      add_vec(2'b01, 2'b01, 5'b00100, 5'b00000, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, S_SPLIT);
      add_vec(2'b01, 2'b00, 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, S_IDLE);
      add_vec(2'b01, 2'b00, 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, S_IDLE);
      add_vec(2'b11, 2'b00, 5'b00000, 5'b00000, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, S_GRANT);
      add_vec(2'b11, 2'b10, 5'b00000, 5'b00000, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, S_BUSY);
      add_vec(2'b11, 2'b10, 5'b00001, 5'b00010, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, S_BUSY);
      add_vec(2'b11, 2'b00, 5'b00000, 5'b00100, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, S_IDLE);
      add_vec(2'b11, 2'b00, 5'b00000, 5'b00100, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, S_GRANT);
      // master1 split by slave 3; resume must beat master0
      add_vec(2'b00, 2'b00, 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, S_IDLE);
      add_vec(2'b10, 2'b00, 5'b00000, 5'b00000, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, S_GRANT);
      add_vec(2'b10, 2'b10, 5'b00000, 5'b00000, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, S_BUSY);
      add_vec(2'b10, 2'b10, 5'b01000, 5'b00000, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, S_SPLIT);
      add_vec(2'b11, 2'b00, 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, S_IDLE);
      add_vec(2'b11, 2'b00, 5'b00000, 5'b00000, 2'b01, 2'b00, 1'b0, 1'b1, 1'b1, S_GRANT);
      add_vec(2'b11, 2'b01, 5'b00000, 5'b00000, 2'b01, 2'b00, 1'b0, 1'b1, 1'b1, S_BUSY);
      add_vec(2'b11, 2'b00, 5'b00000, 5'b01000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, S_IDLE);
      add_vec(2'b11, 2'b00, 5'b00000, 5'b01000, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, S_GRANT);
      // release wins over a simultaneous split request
      add_vec(2'b11, 2'b10, 5'b00000, 5'b00000, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, S_BUSY);
      add_vec(2'b11, 2'b00, 5'b00001, 5'b00000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, S_IDLE);
      add_vec(2'b00, 2'b00, 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, S_IDLE);
      // set up BUSY with a split pending for the reset test
      add_vec(2'b01, 2'b00, 5'b00000, 5'b00000, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, S_GRANT);
      add_vec(2'b01, 2'b01, 5'b00000, 5'b00000, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, S_BUSY);
      add_vec(2'b01, 2'b01, 5'b00100, 5'b00000, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, S_SPLIT);
      add_vec(2'b10, 2'b00, 5'b00000, 5'b00000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, S_IDLE);
      add_vec(2'b10, 2'b00, 5'b00000, 5'b00000, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, S_GRANT);
      add_vec(2'b10, 2'b10, 5'b00000, 5'b00000, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, S_BUSY);

      // reset state
      drive(2'b00, 2'b00, 5'b00000, 5'b00000);
      #12;
      check_reset("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < part_a_end; i++) apply_vec(i);

      // grant timeout: master1 never raises bus_util while master0 waits
      drive(2'b10, 2'b00, 5'b00000, 5'b00000);
      step();
      check("to_grant", 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, S_GRANT);
      drive(2'b11, 2'b00, 5'b00000, 5'b00000);
      for (int k = 1; k < GRANT_TIMEOUT; k++) begin
         step();
         check($sformatf("to_hold%0d", k), 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, S_GRANT);
      end
      step();
      check("to_revoke", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, S_IDLE);
      step();
      check("to_next", 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, S_GRANT);
      drive(2'b00, 2'b00, 5'b00000, 5'b00000);
      step();
      check("to_drop", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, S_IDLE);

      for (int i = part_a_end; i < vecs.size(); i++) apply_vec(i);

      // asynchronous reset while BUSY with a split pending
      #2;
      rst_n = 1'b0;
      #1;
      check_reset("rst_async");
      drive(2'b00, 2'b00, 5'b00000, 5'b00000);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("rst_idle", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, S_IDLE);
      drive(2'b01, 2'b00, 5'b00000, 5'b00000);
      step();
      check("rst_regrant", 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, S_GRANT);

      // final report
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
